// File: rtl/draw_sprites_mux_if.sv
// VGA raster timing plus pixel colour, carried between pipeline stages.
// Latency: none, plain signal bundle. Backpressure: none, streams at pixel rate.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprites_mux.sv
// Multi-sprite overlay from a shared frame-sheet ROM, fixed priority, per-frame collision flag.
// Latency: 3 clk from in.* to out.*; the ROM is read between stage 1 and stage 2.
// Backpressure: none, one pixel per clk with no stall path.
module draw_sprites_mux #(
    parameter int          SPRITES     = 8,
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          FRAMES      = 4,
    parameter logic [11:0] TRANSPARENT = 12'h000,
    parameter logic [11:0] BLANK_RGB   = 12'h888,
    localparam int         FW          = $clog2(FRAMES),
    localparam int         RW          = $clog2(SPR_H),
    localparam int         CW          = $clog2(SPR_W),
    localparam int         AW          = FW + RW + CW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [SPRITES-1:0]           sprite_en,
    input  logic [SPRITES-1:0][10:0]     xpos,
    input  logic [SPRITES-1:0][10:0]     ypos,
    input  logic [SPRITES-1:0][FW-1:0]   frame,
    input  logic [SPRITES-1:0]           flip,
    input  logic [11:0]                  rgb_pixel,
    output logic [AW-1:0]                pixel_addr,
    output logic                         collision,
    vga_if.in                            in,
    vga_if.out                           out
);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } tim_t;

    tim_t in_tim, s1_tim, s2_tim, o_tim;

    logic [SPRITES-1:0]         sh_en;
    logic [SPRITES-1:0][10:0]   sh_x;
    logic [SPRITES-1:0][10:0]   sh_y;
    logic [SPRITES-1:0][FW-1:0] sh_frame;
    logic [SPRITES-1:0]         sh_flip;

    logic        vblnk_prev;
    logic        vblnk_rise;
    logic        coll_acc;
    logic        s1_hit, s2_hit;
    logic [11:0] s2_rom;
    logic [11:0] s3_rgb;

    logic [SPRITES-1:0] hit;
    logic               any_hit;
    logic               multi_hit;
    logic [AW-1:0]      win_addr;
    logic [RW-1:0]      dy;
    logic [CW-1:0]      dx;
    logic [11:0]        h12, v12;

    assign in_tim     = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};
    assign vblnk_rise = in.vblnk && !vblnk_prev;

    // Box test widened to 12 bits so a sprite near x/y=2047 cannot wrap onto column/row 0.
    always_comb begin
        hit = '0;
        h12 = {1'b0, in.hcount};
        v12 = {1'b0, in.vcount};
        for (int i = 0; i < SPRITES; i++) begin
            hit[i] = enable && sh_en[i]
                  && (v12 >= {1'b0, sh_y[i]}) && (v12 < {1'b0, sh_y[i]} + 12'(SPR_H))
                  && (h12 >= {1'b0, sh_x[i]}) && (h12 < {1'b0, sh_x[i]} + 12'(SPR_W));
        end
    end

    // Walk from highest to lowest index so the lowest hitting sprite is the last one written.
    always_comb begin
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        win_addr  = '0;
        dy        = '0;
        dx        = '0;
        for (int i = SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                multi_hit = multi_hit | any_hit;
                any_hit   = 1'b1;
                dy        = RW'(in.vcount - sh_y[i]);
                dx        = CW'(in.hcount - sh_x[i]);
                if (sh_flip[i])
                    dx = CW'(SPR_W - 1) - dx;
                win_addr  = {sh_frame[i], dy, dx};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev <= 1'b0;
            sh_en      <= '0;
            sh_x       <= '0;
            sh_y       <= '0;
            sh_frame   <= '0;
            sh_flip    <= '0;
            coll_acc   <= 1'b0;
            collision  <= 1'b0;
        end else begin
            vblnk_prev <= in.vblnk;
            if (vblnk_rise) begin
                sh_en     <= sprite_en;
                sh_x      <= xpos;
                sh_y      <= ypos;
                sh_frame  <= frame;
                sh_flip   <= flip;
                collision <= coll_acc;
                coll_acc  <= 1'b0;
            end else if (multi_hit && !in.hblnk && !in.vblnk) begin
                coll_acc  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_tim     <= '0;
            s1_hit     <= 1'b0;
            pixel_addr <= '0;
            s2_tim     <= '0;
            s2_hit     <= 1'b0;
            s2_rom     <= '0;
            o_tim      <= '0;
        end else begin
            s1_tim <= in_tim;
            s1_hit <= any_hit;
            if (any_hit)
                pixel_addr <= win_addr;
            s2_tim <= s1_tim;
            s2_hit <= s1_hit;
            s2_rom <= rgb_pixel;
            o_tim  <= s2_tim;
            o_tim.rgb <= s3_rgb;
        end
    end

    // A transparent winner shows the background, never a lower-priority sprite beneath it.
    always_comb begin
        s3_rgb = s2_tim.rgb;
        if (s2_tim.hblnk || s2_tim.vblnk)
            s3_rgb = BLANK_RGB;
        else if (s2_hit && (s2_rom != TRANSPARENT))
            s3_rgb = s2_rom;
    end

    assign out.hcount = o_tim.hcount;
    assign out.vcount = o_tim.vcount;
    assign out.hsync  = o_tim.hsync;
    assign out.vsync  = o_tim.vsync;
    assign out.hblnk  = o_tim.hblnk;
    assign out.vblnk  = o_tim.vblnk;
    assign out.rgb    = o_tim.rgb;

endmodule

// File: doc/draw_sprites_mux.md
Name: draw_sprites_mux

Overview:
Parametrised multi-sprite overlay stage for the VGA pipeline, for barrels, enemies and pickups. It draws up to SPRITES same-size sprites from a shared multi-frame sprite ROM. Each sprite has its own animation frame and horizontal flip, and overlap priority is fixed. Sprite attributes are double-buffered per video frame so they never tear mid-frame. The block reports a per-frame bounding-box collision flag for game logic.

Parameters:
SPRITES, 8, number of sprite channels, 1..16
SPR_W, 32, sprite width in pixels, power of 2
SPR_H, 32, sprite height in pixels, power of 2
FRAMES, 4, animation frames per sprite sheet, power of 2, ≥2
TRANSPARENT, 12'h000, ROM colour treated as see-through
BLANK_RGB, 12'h888, colour driven during blanking

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  global draw enable (game running, no intro animation)
sprite_en  input  [SPRITES-1:0]  per-sprite enable
xpos  input  [SPRITES-1:0][10:0]  sprite left edge
ypos  input  [SPRITES-1:0][10:0]  sprite top edge
frame  input  [SPRITES-1:0][$clog2(FRAMES)-1:0]  animation frame index
flip  input  [SPRITES-1:0]  1 = mirror horizontally
rgb_pixel  input  12  ROM data; valid 1 clk after pixel_addr
pixel_addr  output  $clog2(FRAMES)+$clog2(SPR_H)+$clog2(SPR_W)  ROM address {frame,row,col}
collision  output  1  two or more sprite boxes overlapped on a visible pixel in the last completed frame
in  vga_if.in  -  timing and background rgb
out  vga_if.out  -  timing and composited rgb

Behaviour:
- Reset is asynchronous on the falling edge of rst_n. All outputs, pipeline registers, shadow registers and flags are cleared to 0, so no sprites are drawn after reset.
- Shadow latch: on the rising edge of in.vblnk (registered prev-vblnk 0 → current 1), copy sprite_en, xpos, ypos, frame and flip into shadow registers. All drawing uses the shadows only. Input changes mid-frame take effect from the next frame.
- Pipeline has 3 stages; out.* equals in.* timing delayed exactly 3 clk.
  - S1: hit test every sprite i against in.hcount/in.vcount. Sprite i hits when shadow_en[i] is set and ypos ≤ v < ypos+SPR_H and xpos ≤ h < xpos+SPR_W.
  - Compare in 12 bits (zero-extended) so xpos/ypos near 2047 do not wrap. Off-screen parts clip naturally.
  - S1 priority: the lowest index hitting sprite wins.
  - S1 register: hit_valid, winner address, and pixel_addr = {frame[w], v-ypos[w], col}. col = h-xpos[w], or SPR_W-1-(h-xpos[w]) when flip[w]=1. Differences are truncated to row/col widths.
  - With no hit, or enable=0, pixel_addr holds its previous value.
  - S2: ROM returns rgb_pixel; register it alongside the delayed hit_valid, background rgb and timing.
  - S3 output: blanking (hblnk or vblnk) drives BLANK_RGB. Otherwise, if hit_valid and rgb_pixel≠TRANSPARENT, drive rgb_pixel. Otherwise pass the background rgb through.
- A transparent pixel of the winning sprite shows the background, not the next lower-priority sprite.
- Collision:
  - Internal sticky flag coll_acc is set when enable=1, the pixel is not blanking, and ≥2 shadow sprites hit the same S1 pixel.
  - On the vblnk rising edge, collision <= coll_acc and coll_acc is cleared in the same cycle. collision therefore holds for one full frame.
- enable=0: rgb is passed through (blanking still forced to BLANK_RGB), no hits and no collision accumulation. Shadow latching continues.

Test Plan:
- Reset mid-frame with sprites active → out.rgb=0, collision=0, and no sprite visible in the first frame after release until the first vblnk latch.
- Sprite 0 at (100,200), frame 2, flip=0 → at pixel (105,203): pixel_addr={2,3,5}; out.rgb equals ROM data 3 clk after input; background when ROM returns 12'h000.
- Same sprite with flip=1 → at h=105, col=26 (SPR_W=32).
- Sprites 1 and 3 overlapping at (300,300) → sprite 1 drawn in the overlap; collision=1 for the frame after the next vblnk edge, then 0 the following frame once they are separated.
- Change xpos[0] from 100 to 400 at vcount=240 → remaining lines of that frame still drawn at 100; next frame at 400.
- xpos=2040 (right edge): no wrap-around drawing at h<8. During blanking, out.rgb=12'h888 regardless of sprites.
